// File: rtl/im_config_sequencer.sv
// AXI4-Lite master that writes a table of configuration words into the IM block
// and then reads every register back to verify it.
module im_config_sequencer #(
    parameter int          NUM_REGS       = 4,
    parameter int          ADDR_WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                     M_AXI_ACLK,
    input  logic                     M_AXI_ARESETN,
    input  logic                     INIT_AXI_TXN,
    input  logic [32*NUM_REGS-1:0]   CFG_DATA,
    output logic                     TXN_DONE,
    output logic                     ERROR,
    output logic                     BUSY,
    output logic [ADDR_WIDTH-1:0]    M_AXI_AWADDR,
    output logic [2:0]               M_AXI_AWPROT,
    output logic                     M_AXI_AWVALID,
    input  logic                     M_AXI_AWREADY,
    output logic [31:0]              M_AXI_WDATA,
    output logic [3:0]               M_AXI_WSTRB,
    output logic                     M_AXI_WVALID,
    input  logic                     M_AXI_WREADY,
    input  logic [1:0]               M_AXI_BRESP,
    input  logic                     M_AXI_BVALID,
    output logic                     M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]    M_AXI_ARADDR,
    output logic [2:0]               M_AXI_ARPROT,
    output logic                     M_AXI_ARVALID,
    input  logic                     M_AXI_ARREADY,
    input  logic [31:0]              M_AXI_RDATA,
    input  logic [1:0]               M_AXI_RRESP,
    input  logic                     M_AXI_RVALID,
    output logic                     M_AXI_RREADY
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RD    = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]            state;
    logic [IW-1:0]         idx;
    logic [TW-1:0]         tcnt;
    logic                  init_d, init_q;
    logic                  aw_done, w_done;
    logic                  awvalid, wvalid, bready, arvalid, rready;
    logic [ADDR_WIDTH-1:0] awaddr, araddr;
    logic [31:0]           wdata;
    logic                  error_q;

    logic                  start, aw_fire, w_fire, aw_ok, w_ok;
    logic                  active, progress, timed_out;
    logic [IW-1:0]         idx_nxt;

    function automatic logic [31:0] cfg_word(input logic [IW-1:0] i);
        return CFG_DATA[{i, 5'd0} +: 32];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [IW-1:0] i);
        return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({i, 2'b00});
    endfunction

    assign start   = init_d & ~init_q;
    assign aw_fire = awvalid & M_AXI_AWREADY;
    assign w_fire  = wvalid & M_AXI_WREADY;
    assign aw_ok   = aw_done | aw_fire;
    assign w_ok    = w_done | w_fire;
    assign idx_nxt = idx + IW'(1);
    assign active  = (state == S_WR) || (state == S_WRESP) ||
                     (state == S_RD) || (state == S_RDATA);

    always_comb begin
        progress = 1'b0;
        case (state)
            S_WR:    progress = aw_ok & w_ok;
            S_WRESP: progress = M_AXI_BVALID;
            S_RD:    progress = M_AXI_ARREADY;
            S_RDATA: progress = M_AXI_RVALID;
            default: progress = 1'b0;
        endcase
    end

    // A stalled handshake is abandoned only if it makes no progress on its last allowed cycle
    assign timed_out = active & ~progress & (tcnt == T_LAST);

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state   <= S_IDLE;
            idx     <= '0;
            tcnt    <= '0;
            init_d  <= 1'b0;
            init_q  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awaddr  <= '0;
            araddr  <= '0;
            wdata   <= '0;
            error_q <= 1'b0;
        end else begin
            init_d <= INIT_AXI_TXN;
            init_q <= init_d;
            tcnt   <= tcnt + TW'(1);
            case (state)
                S_IDLE: begin
                    tcnt <= '0;
                    if (start) begin
                        error_q <= 1'b0;
                        idx     <= '0;
                        awaddr  <= reg_addr('0);
                        wdata   <= cfg_word('0);
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        state   <= S_WR;
                    end
                end
                S_WR: begin
                    if (aw_fire) awvalid <= 1'b0;
                    if (w_fire)  wvalid  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        tcnt    <= '0;
                        state   <= S_WRESP;
                    end else begin
                        aw_done <= aw_ok;
                        w_done  <= w_ok;
                    end
                end
                S_WRESP: begin
                    if (M_AXI_BVALID) begin
                        bready <= 1'b0;
                        tcnt   <= '0;
                        if (M_AXI_BRESP != 2'b00) begin
                            error_q <= 1'b1;
                            state   <= S_DONE;
                        end else if (idx == LAST_IDX) begin
                            idx     <= '0;
                            araddr  <= reg_addr('0);
                            arvalid <= 1'b1;
                            state   <= S_RD;
                        end else begin
                            idx     <= idx_nxt;
                            awaddr  <= reg_addr(idx_nxt);
                            wdata   <= cfg_word(idx_nxt);
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= S_WR;
                        end
                    end
                end
                S_RD: begin
                    if (M_AXI_ARREADY) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        tcnt    <= '0;
                        state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (M_AXI_RVALID) begin
                        rready <= 1'b0;
                        tcnt   <= '0;
                        if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != cfg_word(idx)) begin
                            error_q <= 1'b1;
                            state   <= S_DONE;
                        end else if (idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            idx     <= idx_nxt;
                            araddr  <= reg_addr(idx_nxt);
                            arvalid <= 1'b1;
                            state   <= S_RD;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            if (timed_out) begin
                error_q <= 1'b1;
                awvalid <= 1'b0;
                wvalid  <= 1'b0;
                bready  <= 1'b0;
                arvalid <= 1'b0;
                rready  <= 1'b0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                state   <= S_DONE;
            end
        end
    end

    assign TXN_DONE      = (state == S_DONE);
    assign BUSY          = active;
    assign ERROR         = error_q;
    assign M_AXI_AWADDR  = awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid;
    assign M_AXI_WDATA   = wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid;
    assign M_AXI_BREADY  = bready;
    assign M_AXI_ARADDR  = araddr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid;
    assign M_AXI_RREADY  = rready;

endmodule

// File: tb/tb_im_config_sequencer.sv
// Bench for im_config_sequencer: AXI4-Lite memory slave with programmable delays and
// fault injection, a table of directed runs, and hand-written multi-cycle corner cases.
module tb_im_config_sequencer;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          INIT = 1'b0;
    logic [127:0]  CFG = '0;
    logic          TXN_DONE, ERROR, BUSY;
    logic [31:0]   AWADDR, WDATA, ARADDR;
    logic [2:0]    AWPROT, ARPROT;
    logic [3:0]    WSTRB;
    logic          AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic          AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
    logic [1:0]    BRESP = 2'b00, RRESP = 2'b00;
    logic [31:0]   RDATA = '0;

    im_config_sequencer #(
        .NUM_REGS(NR), .ADDR_WIDTH(32), .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(16)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn), .INIT_AXI_TXN(INIT), .CFG_DATA(CFG),
        .TXN_DONE(TXN_DONE), .ERROR(ERROR), .BUSY(BUSY),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
        .M_AXI_AWREADY(AWREADY), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
        .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP),
        .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR),
        .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
        .M_AXI_RREADY(RREADY)
    );

    always #5 clk = ~clk;

    // slave configuration, written only by the test sequence
    int max_dly = 0;
    int err_reg = -1;
    int bad_reg = -1;
    bit aw_block = 1'b0;
    bit proto_en = 1'b1;
    bit slv_clr = 1'b0;

    // slave state, written only by the slave process
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit b_hs, r_hs;
    int n_b, n_r, done_cnt, viol;
    logic [31:0] aw_q[$], w_q[$], ar_q[$];
    logic [31:0] mem[16];
    logic [31:0] a_t;
    logic awv_q, awr_q, wv_q, wr_q, arv_q, arr_q;

    int n_chk = 0;
    int n_fail = 0;

    function automatic int rnd();
        return (max_dly == 0) ? 0 : int'($urandom_range(32'(max_dly), 0));
    endfunction

    // Slave decisions are made on the falling edge; a READY/VALID raised here is
    // seen by the DUT at the next rising edge.
    always @(negedge clk) begin
        if (slv_clr || !rstn) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            BRESP = 0; RRESP = 0; RDATA = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            b_hs = 0; r_hs = 0; n_b = 0; n_r = 0;
            aw_q.delete(); w_q.delete(); ar_q.delete();
            awv_q = 0; awr_q = 0; wv_q = 0; wr_q = 0; arv_q = 0; arr_q = 0;
            if (slv_clr) begin
                done_cnt = 0;
                viol = 0;
            end
        end else begin
            if (proto_en && awv_q && !awr_q && !AWVALID) viol++;
            if (proto_en && wv_q && !wr_q && !WVALID) viol++;
            if (proto_en && arv_q && !arr_q && !ARVALID) viol++;
            if (TXN_DONE) done_cnt++;
            if (b_hs) begin
                BVALID = 0; BRESP = 0; b_hs = 0; n_b++; b_wait = rnd();
            end else begin
                if (!BVALID && aw_q.size() > n_b && w_q.size() > n_b) begin
                    if (b_wait == 0) begin
                        a_t = aw_q[n_b];
                        mem[a_t[5:2]] = w_q[n_b];
                        BRESP = (n_b == err_reg) ? 2'b10 : 2'b00;
                        BVALID = 1;
                    end else b_wait--;
                end
                if (BVALID && BREADY) b_hs = 1;
            end
            if (r_hs) begin
                RVALID = 0; r_hs = 0; n_r++; r_wait = rnd();
            end else begin
                if (!RVALID && ar_q.size() > n_r) begin
                    if (r_wait == 0) begin
                        a_t = ar_q[n_r];
                        RDATA = (n_r == bad_reg) ? 32'h0000DEAD : mem[a_t[5:2]];
                        RRESP = 2'b00;
                        RVALID = 1;
                    end else r_wait--;
                end
                if (RVALID && RREADY) r_hs = 1;
            end
            if (AWREADY) begin AWREADY = 0; aw_wait = rnd(); end
            else if (AWVALID && !aw_block) begin
                if (aw_wait == 0) begin AWREADY = 1; aw_q.push_back(AWADDR); end
                else aw_wait--;
            end
            if (WREADY) begin WREADY = 0; w_wait = rnd(); end
            else if (WVALID) begin
                if (w_wait == 0) begin WREADY = 1; w_q.push_back(WDATA); end
                else w_wait--;
            end
            if (ARREADY) begin ARREADY = 0; ar_wait = rnd(); end
            else if (ARVALID) begin
                if (ar_wait == 0) begin ARREADY = 1; ar_q.push_back(ARADDR); end
                else ar_wait--;
            end
            awv_q = AWVALID; awr_q = AWREADY;
            wv_q = WVALID; wr_q = WREADY;
            arv_q = ARVALID; arr_q = ARREADY;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic clear_slave();
        slv_clr = 1'b1;
        tick();
        slv_clr = 1'b0;
    endtask

    task automatic start();
        INIT = 1'b1;
        tick();
        INIT = 1'b0;
        tick();
    endtask

    task automatic wait_done();
        for (int c = 0; c < 3000; c++) begin
            if (done_cnt > 0) break;
            tick();
        end
        repeat (5) tick();
    endtask

    task automatic check_log(input string tag, input logic [127:0] cfg,
                             input int exp_aw, input int exp_ar);
        check({tag, "_aw_count"}, 32'(aw_q.size()), 32'(exp_aw));
        check({tag, "_ar_count"}, 32'(ar_q.size()), 32'(exp_ar));
        for (int i = 0; i < aw_q.size() && i < NR; i++) begin
            check({tag, "_awaddr"}, aw_q[i], 32'(4 * i));
            if (i < w_q.size()) check({tag, "_wdata"}, w_q[i], cfg[32*i +: 32]);
        end
        for (int i = 0; i < ar_q.size() && i < NR; i++)
            check({tag, "_araddr"}, ar_q[i], 32'(4 * i));
        check({tag, "_protocol"}, 32'(viol), 32'd0);
    endtask

    typedef struct {
        logic [127:0] cfg;
        int           dly;
        int           err;
        int           bad;
        int           exp_aw;
        int           exp_ar;
        bit           exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int hi;
        vecs[0] = '{128'h00000004_00000003_00000002_00000001, 0, -1, -1, 4, 4, 1'b0};
        vecs[1] = '{128'hCAFEF00D_12345678_80000001_FFFFFFFF, 10, -1, -1, 4, 4, 1'b0};
        vecs[2] = '{128'h00000000_A5A5A5A5_5A5A5A5A_DEADBEEF, 10, -1, -1, 4, 4, 1'b0};
        vecs[3] = '{128'h44444444_33333333_22222222_11111111, 3, 2, -1, 3, 0, 1'b1};
        vecs[4] = '{128'h00000004_00000003_00000002_00000001, 0, -1, 3, 4, 4, 1'b1};
        vecs[5] = '{128'h0000000D_0000000C_0000000B_0000000A, 2, -1, 0, 4, 1, 1'b1};
        vecs[6] = '{128'h00000004_00000003_00000002_00000001, 1, 0, -1, 1, 0, 1'b1};
        vecs[7] = '{128'h00000004_00000003_00000002_00000001, 0, 3, -1, 4, 0, 1'b1};

        do_reset();
        check("rst_awvalid", 32'(AWVALID), 32'd0);
        check("rst_wvalid", 32'(WVALID), 32'd0);
        check("rst_bready", 32'(BREADY), 32'd0);
        check("rst_arvalid", 32'(ARVALID), 32'd0);
        check("rst_rready", 32'(RREADY), 32'd0);
        check("rst_flags", {29'd0, TXN_DONE, ERROR, BUSY}, 32'd0);
        check("rst_addr_data", AWADDR | ARADDR | WDATA, 32'd0);
        check("rst_prot_strb", {25'd0, AWPROT, WSTRB}, {25'd0, 3'b000, 4'hF});

        for (int v = 0; v < 8; v++) begin
            max_dly = vecs[v].dly;
            err_reg = vecs[v].err;
            bad_reg = vecs[v].bad;
            CFG = vecs[v].cfg;
            do_reset();
            clear_slave();
            start();
            wait_done();
            check($sformatf("vec%0d_done_pulses", v), 32'(done_cnt), 32'd1);
            check($sformatf("vec%0d_error", v), 32'(ERROR), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_busy", v), 32'(BUSY), 32'd0);
            check_log($sformatf("vec%0d", v), vecs[v].cfg, vecs[v].exp_aw, vecs[v].exp_ar);
        end

        // AWREADY stuck low: the write address is abandoned after the timeout
        max_dly = 0; err_reg = -1; bad_reg = -1;
        CFG = 128'h00000004_00000003_00000002_00000001;
        do_reset();
        clear_slave();
        aw_block = 1'b1;
        proto_en = 1'b0;
        hi = 0;
        INIT = 1'b1;
        tick();
        INIT = 1'b0;
        for (int c = 0; c < 200 && done_cnt == 0; c++) begin
            tick();
            if (AWVALID) hi++;
        end
        repeat (3) tick();
        check("tmo_awvalid_cycles", 32'(hi), 32'd16);
        check("tmo_error", 32'(ERROR), 32'd1);
        check("tmo_done_pulses", 32'(done_cnt), 32'd1);
        check("tmo_valids_dropped", {29'd0, AWVALID, WVALID, BREADY}, 32'd0);

        // Next accepted start clears the sticky error without a reset
        aw_block = 1'b0;
        proto_en = 1'b1;
        clear_slave();
        start();
        check("restart_busy", 32'(BUSY), 32'd1);
        check("restart_err_cleared", 32'(ERROR), 32'd0);
        wait_done();
        check("restart_done", 32'(done_cnt), 32'd1);
        check("restart_error", 32'(ERROR), 32'd0);
        check_log("restart", CFG, 4, 4);

        // A second INIT edge while busy must not restart the sequence
        CFG = 128'h89ABCDEF_01234567_FEDCBA98_76543210;
        max_dly = 2;
        clear_slave();
        start();
        repeat (6) tick();
        INIT = 1'b1;
        tick();
        INIT = 1'b0;
        wait_done();
        repeat (20) tick();
        check("reinit_done_pulses", 32'(done_cnt), 32'd1);
        check("reinit_error", 32'(ERROR), 32'd0);
        check_log("reinit", CFG, 4, 4);

        // Reset while waiting for a write response
        max_dly = 3;
        clear_slave();
        start();
        for (int c = 0; c < 100; c++) begin
            if (BREADY) break;
            tick();
        end
        check("rst_mid_reached_wresp", 32'(BREADY), 32'd1);
        rstn = 1'b0;
        tick();
        check("rst_mid_valids", {27'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 32'd0);
        check("rst_mid_flags", {29'd0, TXN_DONE, ERROR, BUSY}, 32'd0);
        check("rst_mid_addr_data", AWADDR | ARADDR | WDATA, 32'd0);
        tick();
        check("rst_mid_no_done", 32'(done_cnt), 32'd0);
        rstn = 1'b1;
        tick();
        clear_slave();
        start();
        wait_done();
        check("post_rst_done", 32'(done_cnt), 32'd1);
        check("post_rst_error", 32'(ERROR), 32'd0);
        check_log("post_rst", CFG, 4, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
